// File: rtl/rr_requester.sv
// Requester-side agent for a round-robin arbiter: per-channel pending-work
// counters, request generation, grant protocol checking and starvation watchdog.
module rr_requester #(
  parameter int N        = 8,
  parameter int CNT_W    = 4,
  parameter int WAIT_MAX = 32
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_en,
  input  logic [N-1:0] i_push,
  input  logic         i_clr,
  input  logic [N-1:0] i_gnt,
  output logic [N-1:0] o_req,
  output logic         o_pend_any,
  output logic [N-1:0] o_ovf,
  output logic         o_err,
  output logic [N-1:0] o_starve
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       WAIT_LIM = 8'(WAIT_MAX);
  localparam logic [N-1:0]     ONE      = N'(1);

  logic [CNT_W-1:0] cnt      [N];
  logic [CNT_W-1:0] cnt_nxt  [N];
  logic [7:0]       wait_cnt [N];
  logic [7:0]       wait_nxt [N];
  logic [N-1:0]     nz;
  logic [N-1:0]     acc;
  logic [N-1:0]     ovf_set;
  logic [N-1:0]     starve_set;
  logic             err_set;

  always_comb begin
    nz = '0;
    for (int i = 0; i < N; i++) begin
      nz[i] = (cnt[i] != '0);
    end
  end

  // Request is withdrawn while granted so a registered arbiter cannot re-grant the last unit
  assign acc        = i_gnt & nz & {N{i_en}};
  assign o_req      = nz & ~i_gnt & {N{i_en}};
  assign o_pend_any = |nz;

  // Either more than one grant bit, or a grant that cannot be accepted
  assign err_set = ((i_gnt & (i_gnt - ONE)) != '0) ||
                   ((i_gnt & ~(nz & {N{i_en}})) != '0);

  always_comb begin
    ovf_set    = '0;
    starve_set = '0;
    for (int i = 0; i < N; i++) begin
      cnt_nxt[i]  = cnt[i];
      wait_nxt[i] = wait_cnt[i];
      if (i_push[i] && !acc[i]) begin
        if (cnt[i] != CNT_MAX) begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end else begin
          ovf_set[i] = 1'b1;
        end
      end else if (!i_push[i] && acc[i]) begin
        cnt_nxt[i] = cnt[i] - 1'b1;
      end
      if (acc[i]) begin
        wait_nxt[i] = '0;
      end else if (i_en && nz[i] && (wait_cnt[i] != WAIT_LIM)) begin
        wait_nxt[i]   = wait_cnt[i] + 8'd1;
        starve_set[i] = ((wait_cnt[i] + 8'd1) == WAIT_LIM);
      end
    end
  end

  // Sticky flags: a set condition beats a simultaneous clear
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < N; i++) begin
        cnt[i]      <= '0;
        wait_cnt[i] <= '0;
      end
      o_ovf    <= '0;
      o_err    <= 1'b0;
      o_starve <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        cnt[i]      <= cnt_nxt[i];
        wait_cnt[i] <= wait_nxt[i];
      end
      o_ovf    <= (i_clr ? '0 : o_ovf) | ovf_set;
      o_err    <= (i_clr ? 1'b0 : o_err) | err_set;
      o_starve <= (i_clr ? '0 : o_starve) | starve_set;
    end
  end

endmodule

// File: tb/tb_rr_requester.sv
// Self-checking bench for rr_requester: table-driven vectors through a
// scoreboard queue, plus hand-written saturation, starvation and reset sequences.
module tb_rr_requester;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic       i_en;
  logic [7:0] i_push;
  logic       i_clr;
  logic [7:0] i_gnt;
  logic [7:0] o_req;
  logic       o_pend_any;
  logic [7:0] o_ovf;
  logic       o_err;
  logic [7:0] o_starve;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] push;
    logic [7:0] gnt;
    logic       en;
    logic       clr;
    logic [7:0] req;
    logic       pend;
    logic [7:0] ovf;
    logic       err;
    logic [7:0] starve;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];

  rr_requester #(.N(8), .CNT_W(4), .WAIT_MAX(32)) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_en       (i_en),
    .i_push     (i_push),
    .i_clr      (i_clr),
    .i_gnt      (i_gnt),
    .o_req      (o_req),
    .o_pend_any (o_pend_any),
    .o_ovf      (o_ovf),
    .o_err      (o_err),
    .o_starve   (o_starve)
  );

  always #5 i_clk = ~i_clk;

  function automatic vec_t mk(input logic [7:0] push, input logic [7:0] gnt,
                              input logic en, input logic clr,
                              input logic [7:0] req, input logic pend,
                              input logic [7:0] ovf, input logic err,
                              input logic [7:0] starve);
    vec_t v;
    v.push = push; v.gnt = gnt; v.en = en; v.clr = clr;
    v.req = req; v.pend = pend; v.ovf = ovf; v.err = err; v.starve = starve;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the edge and queue its expected outputs
  task automatic applyStimulus(input vec_t v);
    @(posedge i_clk);
    #1;
    i_push = v.push;
    i_gnt  = v.gnt;
    i_en   = v.en;
    i_clr  = v.clr;
    sb.push_back(v);
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    @(negedge i_clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_scoreboard: got empty queue expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    cmp({tag, "_req"},    o_req,             e.req);
    cmp({tag, "_pend"},   {7'b0, o_pend_any}, {7'b0, e.pend});
    cmp({tag, "_ovf"},    o_ovf,             e.ovf);
    cmp({tag, "_err"},    {7'b0, o_err},     {7'b0, e.err});
    cmp({tag, "_starve"}, o_starve,          e.starve);
  endtask

  task automatic cyc(input string tag, input vec_t v);
    applyStimulus(v);
    checkOutput(tag);
  endtask

  task automatic checkZero(input string tag);
    cmp({tag, "_req"},    o_req,              8'h00);
    cmp({tag, "_pend"},   {7'b0, o_pend_any}, 8'h00);
    cmp({tag, "_ovf"},    o_ovf,              8'h00);
    cmp({tag, "_err"},    {7'b0, o_err},      8'h00);
    cmp({tag, "_starve"}, o_starve,           8'h00);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic doReset(input string tag);
    i_push = '0; i_gnt = '0; i_clr = 1'b0; i_en = 1'b1;
    #1 i_rstn = 1'b0;
    #1 checkZero(tag);
    #1 i_rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    i_rstn = 1'b0; i_en = 1'b1; i_push = '0; i_clr = 1'b0; i_gnt = '0;
    #1 checkZero("reset");
    #11 i_rstn = 1'b1;

    // basic request / grant
    tbl.push_back(mk(8'h05, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h05, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h01, 1, 0, 8'h04, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h04, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h04, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00));
    // three units on channel 3, granted on alternate cycles
    tbl.push_back(mk(8'h08, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h08, 8'h00, 1, 0, 8'h08, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h08, 8'h00, 1, 0, 8'h08, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h08, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h08, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h08, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h08, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h08, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00));
    // push while disabled is kept; request waits for enable
    tbl.push_back(mk(8'h10, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h10, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h10, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00));
    // multi-bit grant: error, both valid channels still drain
    tbl.push_back(mk(8'h03, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h03, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h03, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 1, 8'h00, 0, 8'h00, 1, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00));
    // grant to idle channel 7
    tbl.push_back(mk(8'h00, 8'h80, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 1, 8'h00, 0, 8'h00, 1, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00));
    // grant while disabled: error, no accept
    tbl.push_back(mk(8'h01, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h01, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 0, 0, 8'h00, 1, 8'h00, 1, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 1, 8'h01, 1, 8'h00, 1, 8'h00));
    tbl.push_back(mk(8'h00, 8'h01, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00));
    // set wins over simultaneous clear
    tbl.push_back(mk(8'h00, 8'h80, 1, 1, 8'h00, 0, 8'h00, 0, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 1, 8'h00, 0, 8'h00, 1, 8'h00));
    tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00));

    foreach (tbl[k]) cyc($sformatf("vec%0d", k), tbl[k]);

    // saturation on channel 1
    doReset("rst_sat");
    for (int k = 0; k < 16; k++)
      cyc($sformatf("sat_push%0d", k),
          mk(8'h02, 8'h00, 1, 0, (k == 0) ? 8'h00 : 8'h02, (k != 0), 8'h00, 0, 8'h00));
    cyc("sat_ovf",   mk(8'h00, 8'h00, 1, 1, 8'h02, 1, 8'h02, 0, 8'h00));
    cyc("sat_pg",    mk(8'h02, 8'h02, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00));
    cyc("sat_noovf", mk(8'h00, 8'h00, 1, 0, 8'h02, 1, 8'h00, 0, 8'h00));
    for (int k = 1; k <= 15; k++) begin
      cyc($sformatf("sat_g%0d", k), mk(8'h00, 8'h02, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00));
      cyc($sformatf("sat_i%0d", k),
          mk(8'h00, 8'h00, 1, 0, (k < 15) ? 8'h02 : 8'h00, (k < 15), 8'h00, 0, 8'h00));
    end

    // starvation on channel 2
    doReset("rst_stv");
    cyc("stv_push", mk(8'h04, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00));
    for (int j = 1; j <= 33; j++)
      cyc($sformatf("stv_w%0d", j),
          mk(8'h00, 8'h00, 1, 0, 8'h04, 1, 8'h00, 0, (j == 33) ? 8'h04 : 8'h00));
    cyc("stv_gnt",  mk(8'h00, 8'h04, 1, 0, 8'h00, 1, 8'h00, 0, 8'h04));
    cyc("stv_hold", mk(8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h04));
    cyc("stv_clr",  mk(8'h00, 8'h00, 1, 1, 8'h00, 0, 8'h00, 0, 8'h04));
    cyc("stv_gone", mk(8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00));

    // reset in the middle of activity
    cyc("mid_push", mk(8'hFF, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00));
    cyc("mid_gnt",  mk(8'h00, 8'h03, 1, 0, 8'hFC, 1, 8'h00, 0, 8'h00));
    cyc("mid_err",  mk(8'h00, 8'h00, 1, 0, 8'hFC, 1, 8'h00, 1, 8'h00));
    doReset("mid_rst");
    for (int k = 0; k < 3; k++)
      cyc($sformatf("post_idle%0d", k), mk(8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00));
    cyc("post_push", mk(8'h20, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00));
    cyc("post_req",  mk(8'h00, 8'h00, 1, 0, 8'h20, 1, 8'h00, 0, 8'h00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
